// File: rtl/beans_fifo_if.sv
// beans_fifo_if: valid/ready handshake bundle for beans_fifo.
//   in_valid/in_ready/in_data    : producer -> FIFO write side
//   out_valid/out_ready/out_data : FIFO -> consumer read side
// Modports:
//   master : the environment (drives in_valid, in_data, out_ready)
//   slave  : the FIFO (drives in_ready, out_valid, out_data)
interface beans_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/beans_fifo.sv
// beans_fifo: synchronous first-word-fall-through FIFO, single clock domain.
// Ports:
//   clk         : clock, all state changes on rising edge
//   rst         : synchronous active-high reset (highest priority)
//   flush       : synchronous clear of pointers, count and overflow
//   bus         : beans_fifo_if.slave handshake bundle (write and read sides)
//   count       : occupancy 0..DEPTH
//   full/empty  : count == DEPTH / count == 0
//   almost_full : count >= AF_LEVEL
//   overflow    : sticky, set by in_valid while full; cleared by rst/flush
module beans_fifo #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned AF_LEVEL = DEPTH - 2,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    beans_fifo_if.slave       bus,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flags come from the registered count only, so the handshake outputs
    // never depend combinationally on in_valid/out_ready.
    always_comb begin
        full          = (count == CW'(DEPTH));
        empty         = (count == '0);
        almost_full   = (count >= CW'(AF_LEVEL));
        bus.in_ready  = !full;
        bus.out_valid = !empty;
        bus.out_data  = mem[rd_ptr];
        push          = bus.in_valid && !full;
        pop           = !empty && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (bus.in_valid && full)
                overflow <= 1'b1;
        end
    end

    // Storage is never cleared; a push in a rst/flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr] <= bus.in_data;
    end
endmodule

// File: doc/beans_fifo.md
# beans_fifo

Parametrised synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides, occupancy count, almost-full flag and synchronous flush. It is the buffering stage between producers and consumers inside the `beans` datapath, replacing ad-hoc single-register staging. All logic runs in one clock domain.

## Interface

Clocking is fixed: one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 16: number of entries. Must be a power of two, ≥2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when `count` ≥ AF_LEVEL. Legal range is 1..DEPTH.
- `CW`: derived, not overridable. Equals $clog2(DEPTH+1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of contents. Priority is below `rst` and above push/pop.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO can accept data. Equals !full.
- `in_data`  in  WIDTH  write data.
- `out_valid`  out  1  head entry valid. Equals !empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  WIDTH  head entry. Defined only while `out_valid`=1.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `overflow`  out  1  sticky flag: set when in_valid=1 while full. Cleared only by `rst` or `flush`.

## Operation

- Push occurs when in_valid && in_ready. Data is written at `wr_ptr` and `wr_ptr` increments.
- Pop occurs when out_valid && out_ready. `rd_ptr` increments.
- `out_data` is the memory read at `rd_ptr`. It may be a combinational read of the array.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
- Full and empty are derived from `count`, not from pointer comparison.
- `count` update rule:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Simultaneous push and pop:
  - Allowed at any count 1..DEPTH-1, since in_ready and out_valid are both high.
  - Ordering is preserved.
- When full, `in_ready`=0, so no push is possible even if a pop occurs in the same cycle. There is no full pass-through.
- When empty, `out_valid`=0, so no pop is possible. There is no empty bypass: written data is visible the next cycle.
- `in_valid` while full drops the beat, with no write, and sets `overflow`.
- `flush`:
  - Effect: rd_ptr=wr_ptr=0, count=0, overflow=0.
  - Any push or pop presented in the same cycle is ignored.
  - Memory contents are not cleared.
- `rst`: same effect as flush and overrides everything. Memory contents are not reset.
- Handshake: `in_ready` and `out_valid` depend only on registered state, never combinationally on in_valid/out_ready.

## Timing

- Reset values, in the cycle after rst is sampled high:
  - count=0, empty=1, full=0, in_ready=1, out_valid=0
  - almost_full=(AF_LEVEL==0 ? n/a : 0), overflow=0
  - out_data is don't-care.
- Write-to-read latency is 1 cycle. A push accepted at edge N gives out_valid=1 with that data after edge N, if the FIFO was empty.
- `count` and all flags are registered or derived from registered `count`. They reflect pushes and pops from the previous edge.
- Throughput is one push and one pop per cycle sustained.
- `rst` or `flush` asserted mid-burst: the edge on which it is sampled discards all contents. The next cycle shows the empty state above.
- Pointer wrap has no bubble: back-to-back operation across the DEPTH-1→0 boundary is continuous.

## Test plan

- **Reset:** hold rst 2 cycles with random inputs → count=0, empty=1, in_ready=1, out_valid=0, overflow=0.
- **Fill and drain (DEPTH=16):**
  - Push 0x00..0x0F with out_ready=0 → full=1 and in_ready=0 after the 16th push; almost_full first high at count=14.
  - Then pop all 16 → out_data sequence 0x00..0x0F in order, empty=1 at the end.
- **Overflow:** when full, drive in_valid=1 with data 0xAA for 1 cycle → count stays 16, overflow=1 and stays 1; 0xAA never appears at the output.
- **Concurrent push/pop at count=8:** 40 cycles of in_valid=out_ready=1 with an incrementing pattern, crossing the pointer wrap → count constant at 8 and output strictly in order.
- **Flush:** with count=5, assert flush together with in_valid and out_ready → next cycle count=0, empty=1, overflow=0. A subsequent push 0x55 appears 1 cycle later as the only entry.
- **Reset mid-operation:**
  - Assert rst during a concurrent push/pop stream at count=10 → identical to the reset state.
  - The first post-reset push is the first data out.
